// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and default sizes for the reorder buffer
// Purpose: default geometry, entry index width derivation, entry and retire-slot records.
// Ports:   none (package).
package rob_pkg;

   localparam int ROB_DEPTH      = 16;
   localparam int ROB_DISPATCH_W = 4;
   localparam int ROB_CDB_W      = 4;
   localparam int ROB_RETIRE_W   = 4;
   localparam int ROB_XLEN       = 16;
   localparam int ROB_AREG_W     = 4;
   localparam int ROB_IDX_W      = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic                  alloc;
      logic                  done;
      logic [ROB_AREG_W-1:0] target;
      logic [ROB_XLEN-1:0]   data;
   } rob_entry_t;

   typedef struct packed {
      logic                  valid;
      logic [ROB_AREG_W-1:0] target;
      logic [ROB_XLEN-1:0]   data;
      logic [ROB_IDX_W-1:0]  idx;
   } retire_slot_t;

endpackage

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - prefix-AND retire selector
// Purpose: from a per-slot ready vector (slot 0 oldest) keep only the unbroken leading run.
// Ports:   ready in W; mask out W (leading run of ready); n out CNT_W (length of that run).
module rob_retire_sel #(
   parameter int W     = 4,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     ready,
   output logic [W-1:0]     mask,
   output logic [CNT_W-1:0] n
);

   always_comb begin
      logic run;
      run  = 1'b1;
      mask = '0;
      n    = '0;
      // A not-ready slot stops the run, so every younger slot is masked off.
      for (int k = 0; k < W; k++) begin
         run     = run & ready[k];
         mask[k] = run;
         n       = n + CNT_W'(run);
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order-retire reorder buffer with back-pressure and flush
// Purpose: allocate up to DISPATCH_W entries, accept CDB_W completions, retire up to RETIRE_W.
// Ports:   clk, rst_n (async active-low); disp_valid/disp_target in, disp_ready/disp_idx out;
//          cdb_valid/cdb_idx/cdb_data in; flush in; ret_valid/ret_target/ret_data/ret_idx out
//          (registered); entry_done/entry_data out (bypass); count/empty/full out.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH      = ROB_DEPTH,
   parameter int DISPATCH_W = ROB_DISPATCH_W,
   parameter int CDB_W      = ROB_CDB_W,
   parameter int RETIRE_W   = ROB_RETIRE_W,
   parameter int XLEN       = ROB_XLEN,
   parameter int AREG_W     = ROB_AREG_W,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DISPATCH_W-1:0]        disp_valid,
   input  logic [DISPATCH_W*AREG_W-1:0] disp_target,
   output logic                         disp_ready,
   output logic [DISPATCH_W*IDX_W-1:0]  disp_idx,
   input  logic [CDB_W-1:0]             cdb_valid,
   input  logic [CDB_W*IDX_W-1:0]       cdb_idx,
   input  logic [CDB_W*XLEN-1:0]        cdb_data,
   input  logic                         flush,
   output logic [RETIRE_W-1:0]          ret_valid,
   output logic [RETIRE_W*AREG_W-1:0]   ret_target,
   output logic [RETIRE_W*XLEN-1:0]     ret_data,
   output logic [RETIRE_W*IDX_W-1:0]    ret_idx,
   output logic [DEPTH-1:0]             entry_done,
   output logic [DEPTH*XLEN-1:0]        entry_data,
   output logic [IDX_W:0]               count,
   output logic                         empty,
   output logic                         full
);

   localparam int PW = IDX_W + 1;
   localparam int NW = $clog2(RETIRE_W + 1);

   // The record types are sized by the package, so the geometry must agree with it.
   if (XLEN != ROB_XLEN || AREG_W != ROB_AREG_W || IDX_W != ROB_IDX_W ||
       DEPTH < DISPATCH_W || DEPTH < RETIRE_W) begin : g_param_check
      $error("reorder_buffer: parameters inconsistent with rob_pkg record widths");
   end

   logic [PW-1:0]     alloc_ptr, retire_ptr, n_disp;
   logic [DEPTH-1:0]  alloc_q, done_q;
   logic [AREG_W-1:0] target_q [DEPTH];
   logic [XLEN-1:0]   data_q   [DEPTH];

   logic [IDX_W-1:0]  disp_slot_idx [DISPATCH_W];
   logic [IDX_W-1:0]  ret_slot_idx  [RETIRE_W];
   rob_entry_t        ret_entry     [RETIRE_W];
   retire_slot_t      ret_next      [RETIRE_W];
   logic [RETIRE_W-1:0] ret_ready, ret_mask;
   logic [NW-1:0]     ret_n;
   logic              disp_fire;

   // Wrap bit in the pointer MSB makes the subtraction distinguish full from empty.
   assign count      = alloc_ptr - retire_ptr;
   assign empty      = (count == '0);
   assign full       = (count == PW'(DEPTH));
   // Pre-edge occupancy only; same-cycle retires are not credited.
   assign disp_ready = (count <= PW'(DEPTH - DISPATCH_W));
   assign disp_fire  = disp_ready & ~flush;
   assign entry_done = done_q;

   for (genvar i = 0; i < DISPATCH_W; i++) begin : g_disp
      assign disp_slot_idx[i]              = alloc_ptr[IDX_W-1:0] + IDX_W'(i);
      assign disp_idx[i*IDX_W +: IDX_W]    = disp_slot_idx[i];
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      assign entry_data[e*XLEN +: XLEN] = data_q[e];
   end

   for (genvar k = 0; k < RETIRE_W; k++) begin : g_ret
      assign ret_slot_idx[k] = retire_ptr[IDX_W-1:0] + IDX_W'(k);
      assign ret_entry[k]    = '{alloc:  alloc_q[ret_slot_idx[k]],
                                 done:   done_q[ret_slot_idx[k]],
                                 target: target_q[ret_slot_idx[k]],
                                 data:   data_q[ret_slot_idx[k]]};
      assign ret_ready[k]    = ret_entry[k].alloc & ret_entry[k].done & (PW'(k) < count);
      assign ret_next[k]     = '{valid:  ret_mask[k],
                                 target: ret_entry[k].target,
                                 data:   ret_entry[k].data,
                                 idx:    ret_slot_idx[k]};
   end

   always_comb begin
      n_disp = '0;
      for (int i = 0; i < DISPATCH_W; i++) n_disp = n_disp + PW'(disp_valid[i]);
   end

   rob_retire_sel #(.W(RETIRE_W), .CNT_W(NW)) u_retire_sel (
      .ready (ret_ready),
      .mask  (ret_mask),
      .n     (ret_n)
   );

   // Control state. Later writes win: completion, then allocation, then retire clear.
   // Allocated and retired entries are disjoint because disp_ready ignores same-cycle retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr  <= '0;
         retire_ptr <= '0;
         alloc_q    <= '0;
         done_q     <= '0;
         ret_valid  <= '0;
      end else if (flush) begin
         alloc_q    <= '0;
         done_q     <= '0;
         alloc_ptr  <= retire_ptr;
         ret_valid  <= '0;
      end else begin
         for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && alloc_q[cdb_idx[c*IDX_W +: IDX_W]])
               done_q[cdb_idx[c*IDX_W +: IDX_W]] <= 1'b1;
         end
         if (disp_fire) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (disp_valid[i]) begin
                  alloc_q[disp_slot_idx[i]] <= 1'b1;
                  done_q[disp_slot_idx[i]]  <= 1'b0;
               end
            end
            alloc_ptr <= alloc_ptr + n_disp;
         end
         for (int k = 0; k < RETIRE_W; k++) begin
            if (ret_next[k].valid) begin
               alloc_q[ret_slot_idx[k]] <= 1'b0;
               done_q[ret_slot_idx[k]]  <= 1'b0;
            end
            ret_valid[k] <= ret_next[k].valid;
         end
         retire_ptr <= retire_ptr + PW'(ret_n);
      end
   end

   // Payload storage carries no reset; validity is tracked entirely by the control state.
   // Ascending channel order lets the highest channel win on duplicate tags.
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && alloc_q[cdb_idx[c*IDX_W +: IDX_W]])
               data_q[cdb_idx[c*IDX_W +: IDX_W]] <= cdb_data[c*XLEN +: XLEN];
         end
         if (disp_fire) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (disp_valid[i]) target_q[disp_slot_idx[i]] <= disp_target[i*AREG_W +: AREG_W];
            end
         end
         for (int k = 0; k < RETIRE_W; k++) begin
            if (ret_next[k].valid) begin
               ret_target[k*AREG_W +: AREG_W] <= ret_next[k].target;
               ret_data[k*XLEN +: XLEN]       <= ret_next[k].data;
               ret_idx[k*IDX_W +: IDX_W]      <= ret_next[k].idx;
            end
         end
      end
   end

endmodule
